// File: rtl/quadrature_decoder_counter.sv
// Quadrature A/B decoder: synchronises the phases, decodes direction and step
// pulses, keeps a loadable modulo-2^BIT position count and a sticky illegal-jump flag.
module quadrature_decoder_counter #(
    parameter int BIT = 8
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           a_in,
    input  logic           b_in,
    input  logic           load,
    input  logic [BIT-1:0] pre_load,
    output logic [BIT-1:0] count,
    output logic           dir,
    output logic           step,
    output logic           err
);

    typedef enum logic [1:0] {
        MOVE_NONE,
        MOVE_UP,
        MOVE_DOWN,
        MOVE_ILLEGAL
    } move_t;

    logic  a_s1, a_s2, b_s1, b_s2;
    logic  [1:0] prev;
    logic  [1:0] cur;
    move_t move;

    // Synchroniser and history run free through clr, so release never sees a stale phase.
    always_ff @(posedge clk) begin
        a_s1 <= a_in;
        a_s2 <= a_s1;
        b_s1 <= b_in;
        b_s2 <= b_s1;
        prev <= {a_s2, b_s2};
    end

    assign cur = {a_s2, b_s2};

    always_comb begin
        move = MOVE_NONE;
        case ({prev, cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: move = MOVE_UP;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: move = MOVE_DOWN;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: move = MOVE_ILLEGAL;
            default:                                move = MOVE_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
            dir   <= 1'b0;
            step  <= 1'b0;
            err   <= 1'b0;
        end else if (load) begin
            count <= pre_load;
            step  <= 1'b0;
        end else begin
            step <= 1'b0;
            case (move)
                MOVE_UP: begin
                    count <= count + 1'b1;
                    dir   <= 1'b1;
                    step  <= 1'b1;
                end
                MOVE_DOWN: begin
                    count <= count - 1'b1;
                    dir   <= 1'b0;
                    step  <= 1'b1;
                end
                MOVE_ILLEGAL: err <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quadrature_decoder_counter.sv
// Directed self-checking bench for quadrature_decoder_counter (BIT=8).
module tb_quadrature_decoder_counter;

    logic       clk = 1'b0;
    logic       clr;
    logic       a_in;
    logic       b_in;
    logic       load;
    logic [7:0] pre_load;
    logic [7:0] count;
    logic       dir;
    logic       step;
    logic       err;

    int checks   = 0;
    int failures = 0;

    quadrature_decoder_counter #(.BIT(8)) dut (
        .clk      (clk),
        .clr      (clr),
        .a_in     (a_in),
        .b_in     (b_in),
        .load     (load),
        .pre_load (pre_load),
        .count    (count),
        .dir      (dir),
        .step     (step),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_ab(input logic [1:0] ab);
        {a_in, b_in} = ab;
    endtask

    // Drive a phase, verify output latency, then hold for a total of 4 cycles.
    task automatic phase_step(input logic [1:0] ab, input int prev_cnt, input int exp_cnt,
                              input int exp_dir, input int exp_step, input int exp_err);
        set_ab(ab);
        tick();
        tick();
        check("latency_step", step, 0);
        check("latency_count", count, prev_cnt);
        tick();
        check("step", step, exp_step);
        check("count", count, exp_cnt);
        check("dir", dir, exp_dir);
        check("err", err, exp_err);
        tick();
        check("step_low", step, 0);
    endtask

    task automatic do_clear(input int cycles);
        clr = 1'b1;
        repeat (cycles) tick();
        clr = 1'b0;
    endtask

    logic [1:0] seq [8] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};

    initial begin
        clr = 1'b1;
        load = 1'b0;
        pre_load = '0;
        set_ab(2'b11);

        // Reset held with A/B=11, then released while held
        repeat (4) tick();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_count", count, 0);
            check("rst_step", step, 0);
            check("rst_err", err, 0);
        end
        check("rst_dir", dir, 0);

        // Walk back to 00, then clear so the up sequence starts at zero
        phase_step(2'b10, 0, 1, 1, 1, 0);
        phase_step(2'b00, 1, 2, 1, 1, 0);
        do_clear(4);
        check("clr_count", count, 0);
        check("clr_dir", dir, 0);

        // Up sequence 0 -> 4
        phase_step(2'b01, 0, 1, 1, 1, 0);
        phase_step(2'b11, 1, 2, 1, 1, 0);
        phase_step(2'b10, 2, 3, 1, 1, 0);
        phase_step(2'b00, 3, 4, 1, 1, 0);

        // Down wrap from 0, then back up
        do_clear(4);
        phase_step(2'b10, 0, 255, 0, 1, 0);
        phase_step(2'b00, 255, 0, 1, 1, 0);

        // Load coincident with a decoded up transition
        set_ab(2'b01);
        tick();
        tick();
        load = 1'b1;
        pre_load = 8'd200;
        tick();
        load = 1'b0;
        check("load_count", count, 200);
        check("load_step", step, 0);
        check("load_dir", dir, 1);
        tick();
        check("load_hold", count, 200);
        phase_step(2'b11, 200, 201, 1, 1, 0);

        // Illegal jump 11 -> 00, then four valid ups with err sticky
        phase_step(2'b00, 201, 201, 1, 0, 1);
        phase_step(2'b01, 201, 202, 1, 1, 1);
        phase_step(2'b11, 202, 203, 1, 1, 1);
        phase_step(2'b10, 203, 204, 1, 1, 1);
        phase_step(2'b00, 204, 205, 1, 1, 1);
        do_clear(1);
        check("err_cleared", err, 0);
        check("err_clr_count", count, 0);

        // Back-to-back transitions, one per cycle
        tick();
        for (int k = 0; k <= 10; k++) begin
            if (k < 8) set_ab(seq[k]);
            tick();
            check("b2b_step", step, (k >= 2 && k <= 9) ? 1 : 0);
            check("b2b_count", count, (k < 2) ? 0 : ((k > 9) ? 8 : k - 1));
        end
        check("b2b_err", err, 0);
        check("b2b_dir", dir, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quadrature_decoder_counter.md
# quadrature_decoder_counter

Decodes a two-phase quadrature signal pair (A/B) from an incremental encoder into direction, single-cycle step pulses and a loadable up/down position count. It is the input-side companion to the team's up/down counters: it derives the direction and enable that such counters consume, and keeps the position count internally. The A/B inputs are asynchronous to `clk` and are synchronised inside the block. Illegal phase jumps are flagged with a sticky error.

## Interface
- `BIT`, default 8: width of `pre_load` and `count`.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `clr`  input  1  synchronous, active-high reset.
- `a_in`  input  1  encoder phase A; asynchronous.
- `b_in`  input  1  encoder phase B; asynchronous.
- `load`  input  1  synchronous load of `pre_load` into `count`.
- `pre_load`  input  BIT  value loaded on `load`.
- `count`  output  BIT  position count, registered.
- `dir`  output  1  last decoded direction: 1 = up, 0 = down. Registered.
- `step`  output  1  one-cycle pulse per valid decoded transition. Registered.
- `err`  output  1  sticky illegal-transition flag. Registered.

## Operation
- **Synchroniser:** two flops per phase, `a_in`→`a_s1`→`a_s2` (same for B).
  - These flops are not reset; they sample every cycle, including during `clr`.
- **Previous-state register:** `prev` holds the last `{a_s2,b_s2}`.
  - It loads `{a_s2,b_s2}` every cycle, including during `clr`.
  - As a result, no transition is decoded on the first cycle after `clr` is released.
- **Decode** compares `cur={a_s2,b_s2}` with `prev` every cycle:
  - **Up:** 00→01, 01→11, 11→10, 10→00. Result: `count+1`, `dir=1`, `step=1`.
  - **Down:** 00→10, 10→11, 11→01, 01→00. Result: `count-1`, `dir=0`, `step=1`.
  - **No change:** `count` and `dir` hold, `step=0`.
  - **Both bits change** (00↔11, 01↔10): `err=1`, `count` and `dir` hold, `step=0`.
- **Arithmetic:** modulo 2^BIT. `2^BIT-1` +1 → 0; 0 −1 → `2^BIT-1`. No saturation, no overflow flag.
- **Priority per edge:** `clr` > `load` > decode.
  - `clr`: `count=0`, `dir=0`, `step=0`, `err=0`.
  - `load`: `count=pre_load`, `step=0`, `dir` holds, `err` holds. A transition decoded in the same cycle is discarded, and an illegal transition in that cycle does not set `err`.
- **`err` clearing:** `err` is cleared only by `clr`. Once set, decoding continues normally.
- **Reset values:** `count=0`, `dir=0`, `step=0`, `err=0`.

## Timing
- Input changes are first captured by `a_s1`/`b_s1` at edge E0 and reach `a_s2`/`b_s2` at E1.
- `count`, `dir`, `step` and `err` update at E2. Latency from capture to outputs is 2 cycles.
- `step` is high for exactly the one cycle following E2. Consecutive valid transitions spaced one cycle apart give back-to-back `step` pulses and `count` changes every cycle.
- Every phase state must be stable for at least one sampling edge. If A and B both change between two sampling edges, the block reports an illegal transition.
- `load` and `clr` take effect at the edge where they are sampled high; the new `count` is visible the next cycle.
- `clr` held for multiple cycles keeps all outputs at their reset values. When `clr` releases mid-rotation, counting resumes from the next real transition with no spurious step.

## Test plan
- **Reset:** assert `clr` 2 cycles with A/B=11, then release and hold A/B → `count=0`, `step=0`, `err=0` for 10 cycles.
- **Up sequence:** from 00, drive 01, 11, 10, 00, each held 4 cycles. Expect `count` 0→4, four single-cycle `step` pulses, `dir=1`, each appearing 2 cycles after capture.
- **Down wrap:** with BIT=8, drive one down transition from `count=0`. Expect `count=255` and `dir=0`. Then one up transition: expect `count=0`.
- **Load:** `load=1`, `pre_load=200` in the same cycle as a decoded up transition. Expect `count=200`, `step=0`. The next up transition gives 201.
- **Illegal jump:** drive 00→11 in one step. Expect `err=1`, `count` unchanged, `step=0`. Then do 4 valid up transitions: `count` +4 and `err` stays 1 until `clr`.
- **Back-to-back:** change phase every cycle for 8 up transitions. Expect 8 consecutive `step` cycles and `count` +8.
